// File: rtl/pll_sup_pkg.sv
// -----------------------------------------------------------------------------
// pll_sup_pkg
// Shared types and constants for the PLL lock supervisor.
//   state_e        : supervisor state encoding
//   DEF_*          : default parameter values for pll_lock_supervisor
//   max3()         : largest of three cycle counts
//   timer_width()  : bits needed for a down-counter loaded with (cycles-1)
// -----------------------------------------------------------------------------
package pll_sup_pkg;

   typedef enum logic [2:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      STABILIZE = 3'd2,
      RUN       = 3'd3,
      FAULT     = 3'd4
   } state_e;

   localparam int unsigned DEF_RST_PULSE_CYCLES    = 32'd16;
   localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 32'd50000;
   localparam int unsigned DEF_STABLE_CYCLES       = 32'd1024;
   localparam int unsigned DEF_CNT_W               = 32'd8;

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return m;
   endfunction

   // The timer holds at most (cycles-1), so clog2(cycles) bits suffice.
   function automatic int unsigned timer_width(input int unsigned cycles);
      return (cycles <= 32'd2) ? 32'd1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/pll_lock_supervisor_bit_sync.sv
// -----------------------------------------------------------------------------
// bit_sync
// Two-flop single-bit synchronizer, asynchronous active-low reset to 0.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset
//   d_i   : asynchronous input bit
//   q_o   : synchronized output bit
// -----------------------------------------------------------------------------
module bit_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two-stage capture of the asynchronous input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
// Drives the video PLL reset, watches its lock output, and holds the video
// domain in reset until lock has been stable for STABLE_CYCLES refclk cycles.
// Re-cycles the PLL on lock loss in RUN and on lock timeout.
//   clk         : 50 MHz reference clock (same net as PLL refclk)
//   rst_n       : asynchronous active-low reset
//   locked      : PLL lock, asynchronous to clk
//   pll_rst     : active-high PLL reset
//   sys_rst_n   : active-low downstream reset, high only in RUN
//   lock_ok     : high only in RUN
//   fault       : high in FAULT (tied low when auto-retry is compiled in)
//   relock_cnt  : saturating count of lock losses seen in RUN
//   timeout_cnt : saturating count of lock timeouts
// Build option: define PLL_SUP_AUTORETRY_EN to retry indefinitely on timeout
// instead of latching FAULT.
// -----------------------------------------------------------------------------
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int unsigned RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
   parameter int unsigned STABLE_CYCLES       = DEF_STABLE_CYCLES,
   parameter int unsigned CNT_W               = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             locked,
   output logic             pll_rst,
   output logic             sys_rst_n,
   output logic             lock_ok,
   output logic             fault,
   output logic [CNT_W-1:0] relock_cnt,
   output logic [CNT_W-1:0] timeout_cnt
);

   localparam int unsigned TMR_W =
      timer_width(max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES));

   // Each timed state is left on the edge that finds the timer at zero,
   // so loading (cycles-1) gives a dwell of exactly 'cycles' edges.
   localparam logic [TMR_W-1:0] RST_LOAD  = TMR_W'(RST_PULSE_CYCLES - 32'd1);
   localparam logic [TMR_W-1:0] WAIT_LOAD = TMR_W'(LOCK_TIMEOUT_CYCLES - 32'd1);
   localparam logic [TMR_W-1:0] STAB_LOAD = TMR_W'(STABLE_CYCLES - 32'd1);

   state_e           state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [CNT_W-1:0] relock_cnt_q, relock_cnt_d;
   logic [CNT_W-1:0] timeout_cnt_q, timeout_cnt_d;
   logic             pll_rst_q, sys_rst_n_q, lock_ok_q, fault_q;
   logic             locked_s;
   logic             tmr_zero_s;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   function automatic logic [TMR_W-1:0] tmr_load(input state_e s);
      logic [TMR_W-1:0] r;
      case (s)
         PLL_RST:   r = RST_LOAD;
         WAIT_LOCK: r = WAIT_LOAD;
         STABILIZE: r = STAB_LOAD;
         default:   r = {TMR_W{1'b0}};
      endcase
      return r;
   endfunction

   bit_sync u_lock_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (locked),
      .q_o   (locked_s)
   );

   assign tmr_zero_s = (tmr_q == {TMR_W{1'b0}});

   // Next-state, shared timer and event counter logic.
   always_comb begin
      state_d       = state_q;
      relock_cnt_d  = relock_cnt_q;
      timeout_cnt_d = timeout_cnt_q;
      case (state_q)
         PLL_RST: begin
            if (tmr_zero_s) state_d = WAIT_LOCK;
            else            state_d = PLL_RST;
         end
         WAIT_LOCK: begin
            // Lock takes priority over a coincident timeout.
            if (locked_s) begin
               state_d = STABILIZE;
            end else if (tmr_zero_s) begin
               timeout_cnt_d = sat_inc(timeout_cnt_q);
`ifdef PLL_SUP_AUTORETRY_EN
               state_d = PLL_RST;
`else
               state_d = FAULT;
`endif
            end else begin
               state_d = WAIT_LOCK;
            end
         end
         STABILIZE: begin
            if (!locked_s)       state_d = WAIT_LOCK;
            else if (tmr_zero_s) state_d = RUN;
            else                 state_d = STABILIZE;
         end
         RUN: begin
            if (!locked_s) begin
               relock_cnt_d = sat_inc(relock_cnt_q);
               state_d      = PLL_RST;
            end else begin
               state_d = RUN;
            end
         end
         FAULT:   state_d = FAULT;
         default: state_d = PLL_RST;
      endcase

      // One timer for all timed states, reloaded on every transition.
      if (state_d != state_q)   tmr_d = tmr_load(state_d);
      else if (!tmr_zero_s)     tmr_d = tmr_q - TMR_W'(1);
      else                      tmr_d = tmr_q;
   end

   // State, timer, counters and outputs decoded from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= PLL_RST;
         tmr_q         <= RST_LOAD;
         relock_cnt_q  <= {CNT_W{1'b0}};
         timeout_cnt_q <= {CNT_W{1'b0}};
         pll_rst_q     <= 1'b1;
         sys_rst_n_q   <= 1'b0;
         lock_ok_q     <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         tmr_q         <= tmr_d;
         relock_cnt_q  <= relock_cnt_d;
         timeout_cnt_q <= timeout_cnt_d;
         pll_rst_q     <= (state_d == PLL_RST) || (state_d == FAULT);
         sys_rst_n_q   <= (state_d == RUN);
         lock_ok_q     <= (state_d == RUN);
`ifdef PLL_SUP_AUTORETRY_EN
         fault_q       <= 1'b0;
`else
         fault_q       <= (state_d == FAULT);
`endif
      end
   end

   assign pll_rst     = pll_rst_q;
   assign sys_rst_n   = sys_rst_n_q;
   assign lock_ok     = lock_ok_q;
   assign fault       = fault_q;
   assign relock_cnt  = relock_cnt_q;
   assign timeout_cnt = timeout_cnt_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with RST_PULSE=4, TIMEOUT=100, STABLE=8.
// Outputs are sampled 1 ns after each rising edge; inputs change at that point.
module tb_pll_lock_supervisor;

   logic       clk;
   logic       rst_n;
   logic       locked;
   logic       pll_rst;
   logic       sys_rst_n;
   logic       lock_ok;
   logic       fault;
   logic [7:0] relock_cnt;
   logic [7:0] timeout_cnt;

   int checks;
   int failures;
   int exp_relock;

   pll_lock_supervisor #(
      .RST_PULSE_CYCLES    (4),
      .LOCK_TIMEOUT_CYCLES (100),
      .STABLE_CYCLES       (8),
      .CNT_W               (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .locked      (locked),
      .pll_rst     (pll_rst),
      .sys_rst_n   (sys_rst_n),
      .lock_ok     (lock_ok),
      .fault       (fault),
      .relock_cnt  (relock_cnt),
      .timeout_cnt (timeout_cnt)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic step_n(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_release(input int budget, input string tag);
      int n;
      n = 0;
      while (sys_rst_n !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      check(tag, {31'd0, sys_rst_n}, 32'd1);
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      rst_n      = 1'b0;
      locked     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_pll_rst",   {31'd0, pll_rst},   32'd1);
      check("rst_sys_rst_n", {31'd0, sys_rst_n}, 32'd0);
      check("rst_lock_ok",   {31'd0, lock_ok},   32'd0);
      check("rst_fault",     {31'd0, fault},     32'd0);
      check("rst_relock",    {24'd0, relock_cnt},  32'd0);
      check("rst_timeout",   {24'd0, timeout_cnt}, 32'd0);

      // Clean start: pll_rst high across the first 4 edges after release.
      rst_n = 1'b1;
      step();
      check("pulse_e1", {31'd0, pll_rst}, 32'd1);
      step_n(2);
      check("pulse_e3", {31'd0, pll_rst}, 32'd1);
      step();
      check("pulse_e4", {31'd0, pll_rst}, 32'd0);
      step_n(16);
      locked = 1'b1;                 // next edge is k
      step_n(10);                    // after k+9
      check("clean_k9_sys_rst_n", {31'd0, sys_rst_n}, 32'd0);
      step();                        // after k+10
      check("clean_k10_sys_rst_n", {31'd0, sys_rst_n}, 32'd1);
      check("clean_k10_lock_ok",   {31'd0, lock_ok},   32'd1);
      check("clean_pll_rst",       {31'd0, pll_rst},   32'd0);

      // Loss in RUN.
      locked = 1'b0;                 // next edge is j
      step_n(2);                     // after j+1
      check("loss_j1_sys_rst_n", {31'd0, sys_rst_n}, 32'd1);
      step();                        // after j+2
      check("loss_j2_sys_rst_n", {31'd0, sys_rst_n}, 32'd0);
      check("loss_j2_lock_ok",   {31'd0, lock_ok},   32'd0);
      check("loss_j2_pll_rst",   {31'd0, pll_rst},   32'd1);
      check("loss_j2_relock",    {24'd0, relock_cnt}, 32'd1);
      step_n(3);                     // after j+5
      check("loss_j5_pll_rst", {31'd0, pll_rst}, 32'd1);
      step();                        // after j+6
      check("loss_j6_pll_rst", {31'd0, pll_rst}, 32'd0);

      // Glitch during stabilize: one low cycle restarts the 8-cycle count.
      locked = 1'b1;                 // next edge is k2
      step_n(8);                     // after k2+7
      locked = 1'b0;
      step();                        // after g = k2+8
      locked = 1'b1;
      step_n(2);                     // after g+2 (unglitched release point)
      check("glitch_g2_sys_rst_n", {31'd0, sys_rst_n}, 32'd0);
      step_n(8);                     // after g+10
      check("glitch_g10_sys_rst_n", {31'd0, sys_rst_n}, 32'd0);
      step();                        // after g+11
      check("glitch_g11_sys_rst_n", {31'd0, sys_rst_n}, 32'd1);
      check("glitch_relock",        {24'd0, relock_cnt}, 32'd1);

      // Saturation: 300 further lock losses.
      exp_relock = 1;
      for (int i = 0; i < 300; i++) begin
         locked = 1'b0;
         step_n(3);
         exp_relock = (exp_relock == 255) ? 255 : exp_relock + 1;
         check("sat_relock", {24'd0, relock_cnt}, exp_relock[31:0]);
         locked = 1'b1;
         wait_release(40, "sat_release");
      end
      check("sat_final", {24'd0, relock_cnt}, 32'd255);

      // Async reset mid-RUN takes effect without a clock edge.
      rst_n  = 1'b0;
      locked = 1'b0;
      #2;
      check("arst_sys_rst_n", {31'd0, sys_rst_n}, 32'd0);
      check("arst_lock_ok",   {31'd0, lock_ok},   32'd0);
      check("arst_pll_rst",   {31'd0, pll_rst},   32'd1);
      check("arst_relock",    {24'd0, relock_cnt},  32'd0);
      check("arst_timeout",   {24'd0, timeout_cnt}, 32'd0);
      step_n(2);

      // Timeout: 4 reset edges plus 100 wait edges.
      rst_n = 1'b1;
      step_n(103);
      check("to_e103_pll_rst", {31'd0, pll_rst}, 32'd0);
      check("to_e103_timeout", {24'd0, timeout_cnt}, 32'd0);
      step();
      check("to_e104_pll_rst", {31'd0, pll_rst}, 32'd1);
      check("to_e104_timeout", {24'd0, timeout_cnt}, 32'd1);
`ifdef PLL_SUP_AUTORETRY_EN
      check("to_e104_fault", {31'd0, fault}, 32'd0);
      step_n(3);
      check("to_e107_pll_rst", {31'd0, pll_rst}, 32'd1);
      step();
      check("to_e108_pll_rst", {31'd0, pll_rst}, 32'd0);
      step_n(99);
      check("to_e207_pll_rst", {31'd0, pll_rst}, 32'd0);
      step();
      check("to_e208_pll_rst", {31'd0, pll_rst}, 32'd1);
      check("to_e208_timeout", {24'd0, timeout_cnt}, 32'd2);
      check("to_e208_fault",   {31'd0, fault}, 32'd0);
`else
      check("to_e104_fault",     {31'd0, fault},     32'd1);
      check("to_e104_sys_rst_n", {31'd0, sys_rst_n}, 32'd0);
      locked = 1'b1;
      step_n(30);
      check("fault_held",         {31'd0, fault},     32'd1);
      check("fault_pll_rst",      {31'd0, pll_rst},   32'd1);
      check("fault_sys_rst_n",    {31'd0, sys_rst_n}, 32'd0);
      check("fault_lock_ok",      {31'd0, lock_ok},   32'd0);
      check("fault_timeout_cnt",  {24'd0, timeout_cnt}, 32'd1);
`endif

      // Only rst_n clears the fault and the counters.
      rst_n = 1'b0;
      #2;
      check("final_fault",   {31'd0, fault}, 32'd0);
      check("final_timeout", {24'd0, timeout_cnt}, 32'd0);
      check("final_pll_rst", {31'd0, pll_rst}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
